// File: rtl/fft_sample_dma.sv
// Sample-buffer DMA: Avalon-MM slave for CSRs/buffer access, Avalon-MM master moving words
// between the on-chip sample SRAM and system memory. Optional irq output with FFT_DMA_IRQ_EN.
module fft_sample_dma #(
  parameter int MASTER_ADDRESSWIDTH = 32,
  parameter int DATAWIDTH           = 32,
  parameter int SAMPLE_WIDTH        = 16,
  parameter int DEPTH_LOG2          = 9,
  parameter int SLAVE_ADDRESSWIDTH  = DEPTH_LOG2 + 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           slave_chipselect,
  input  logic                           slave_read,
  input  logic                           slave_write,
  input  logic [SLAVE_ADDRESSWIDTH-1:0]  slave_address,
  input  logic [DATAWIDTH-1:0]           slave_writedata,
  output logic [DATAWIDTH-1:0]           slave_readdata,
  output logic                           slave_readdatavalid,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic                           master_write,
  output logic                           master_read,
  output logic [DATAWIDTH-1:0]           master_writedata,
  input  logic [DATAWIDTH-1:0]           master_readdata,
  input  logic                           master_readdatavalid,
  input  logic                           master_waitrequest,
  output logic                           f_wren,
  output logic                           f_rden,
  output logic [DEPTH_LOG2-1:0]          f_address,
  output logic [SAMPLE_WIDTH-1:0]        f_data,
`ifdef FFT_DMA_IRQ_EN
  output logic                           irq,
`endif
  input  logic [SAMPLE_WIDTH-1:0]        f_q
);

  localparam int MAW   = MASTER_ADDRESSWIDTH;
  localparam int CW    = DEPTH_LOG2 + 1;
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int BYTES = DATAWIDTH / 8;

  typedef enum logic [2:0] {IDLE, FETCH, FWAIT, WR, RD, RWAIT, STORE, DONE} state_t;

  // Master handshake: a strobe is held with address/data stable until a cycle
  // with !master_waitrequest; read data is taken on master_readdatavalid.
  state_t state, state_n;

  logic [CW-1:0]  idx, idx_n, run_len, len_q;
  logic [MAW-1:0] addr_q;
  logic           dir_q, done_q, err_q, mask_bit;
  logic           busy, last;
  logic           sel_csr, buf_wr, buf_rd, csr_wr, csr_rd;
  logic [1:0]     csr_idx;
  logic           start_wr, launch, done_set, err_set, clr_done, clr_err;
  logic           rd_s1, rd_s1_z, rd_s2, rd_s2_z;
  logic [DATAWIDTH-1:0] csr_val;
  logic           unused_rdata;

  assign unused_rdata = ^master_readdata;

  assign busy     = (state != IDLE);
  assign sel_csr  = slave_address[SLAVE_ADDRESSWIDTH-1];
  assign csr_idx  = slave_address[1:0];
  assign buf_wr   = slave_chipselect & slave_write & ~sel_csr;
  assign buf_rd   = slave_chipselect & slave_read  & ~sel_csr;
  assign csr_wr   = slave_chipselect & slave_write &  sel_csr;
  assign csr_rd   = slave_chipselect & slave_read  &  sel_csr;
  assign start_wr = csr_wr && (csr_idx == 2'd0) && slave_writedata[0];
  assign launch   = start_wr && !busy && (len_q != '0);
  assign last     = ((idx + CW'(1)) == run_len);

  assign done_set = (state == DONE) || (start_wr && !busy && (len_q == '0));
  assign err_set  = (start_wr && busy) || (buf_wr && busy);
  assign clr_done = csr_wr && (csr_idx == 2'd3) && slave_writedata[1];
  assign clr_err  = csr_wr && (csr_idx == 2'd3) && slave_writedata[2];

  always_comb begin
    state_n = state;
    idx_n   = idx;
    case (state)
      IDLE: begin
        if (launch) begin
          idx_n   = '0;
          state_n = slave_writedata[1] ? RD : FETCH;
        end
      end
      FETCH: state_n = FWAIT;
      FWAIT: state_n = WR;
      WR: begin
        if (!master_waitrequest) begin
          idx_n   = idx + CW'(1);
          state_n = last ? DONE : FETCH;
        end
      end
      RD:    if (!master_waitrequest) state_n = RWAIT;
      RWAIT: if (master_readdatavalid) state_n = STORE;
      STORE: begin
        idx_n   = idx + CW'(1);
        state_n = last ? DONE : RD;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    csr_val = '0;
    case (csr_idx)
      2'd0:    csr_val[2:0] = {mask_bit, dir_q, 1'b0};
      2'd1:    csr_val = DATAWIDTH'(addr_q);
      2'd2:    csr_val = DATAWIDTH'(len_q);
      default: csr_val[2:0] = {err_q, done_q, busy};
    endcase
  end

  // FSM, master port and SRAM strobes; strobes are registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      run_len          <= '0;
      master_address   <= '0;
      master_write     <= 1'b0;
      master_read      <= 1'b0;
      master_writedata <= '0;
      f_wren           <= 1'b0;
      f_rden           <= 1'b0;
      f_address        <= '0;
      f_data           <= '0;
    end else begin
      state        <= state_n;
      idx          <= idx_n;
      master_write <= (state_n == WR);
      master_read  <= (state_n == RD);
      if (launch) begin
        master_address <= addr_q;
        run_len        <= len_q;
      end else if (((state == WR) || (state == RD)) && !master_waitrequest) begin
        master_address <= master_address + MAW'(BYTES);
      end
      if (state == FWAIT) master_writedata <= DATAWIDTH'(f_q);
      // The FSM owns the SRAM while busy; slave buffer accesses only get through in IDLE.
      f_rden <= (state_n == FETCH) || (buf_rd && !busy);
      f_wren <= (state_n == STORE) || (buf_wr && !busy);
      if ((state_n == FETCH) || (state_n == STORE)) begin
        f_address <= idx_n[DEPTH_LOG2-1:0];
      end else if ((buf_rd || buf_wr) && !busy) begin
        f_address <= slave_address[DEPTH_LOG2-1:0];
      end
      if (state_n == STORE) begin
        f_data <= master_readdata[SAMPLE_WIDTH-1:0];
      end else if (buf_wr && !busy) begin
        f_data <= slave_writedata[SAMPLE_WIDTH-1:0];
      end
    end
  end

  // CSRs and the slave read-return pipeline.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q              <= '0;
      len_q               <= '0;
      dir_q               <= 1'b0;
      done_q              <= 1'b0;
      err_q               <= 1'b0;
      rd_s1               <= 1'b0;
      rd_s1_z             <= 1'b0;
      rd_s2               <= 1'b0;
      rd_s2_z             <= 1'b0;
      slave_readdata      <= '0;
      slave_readdatavalid <= 1'b0;
    end else begin
      if (csr_wr) begin
        case (csr_idx)
          2'd0: dir_q  <= slave_writedata[1];
          2'd1: addr_q <= MAW'(slave_writedata);
          2'd2: len_q  <= (slave_writedata > DATAWIDTH'(DEPTH)) ? CW'(DEPTH)
                                                                : CW'(slave_writedata);
          default: ;
        endcase
      end
      done_q  <= done_set | (done_q & ~clr_done);
      err_q   <= err_set  | (err_q  & ~clr_err);
      rd_s1   <= buf_rd;
      rd_s1_z <= busy;
      rd_s2   <= rd_s1;
      rd_s2_z <= rd_s1_z;
      // A buffer read returning in the same cycle as a CSR read takes the bus.
      if (rd_s2) begin
        slave_readdata      <= rd_s2_z ? '0 : DATAWIDTH'(f_q);
        slave_readdatavalid <= 1'b1;
      end else if (csr_rd) begin
        slave_readdata      <= csr_val;
        slave_readdatavalid <= 1'b1;
      end else begin
        slave_readdatavalid <= 1'b0;
      end
    end
  end

`ifdef FFT_DMA_IRQ_EN
  logic mask_q;
  assign mask_bit = mask_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_q <= 1'b0;
      irq    <= 1'b0;
    end else begin
      if (csr_wr && (csr_idx == 2'd0)) mask_q <= slave_writedata[2];
      irq <= mask_q & (done_q | err_q);
    end
  end
`else
  assign mask_bit = 1'b0;
`endif

endmodule

// File: doc/fft_sample_dma.md
# fft_sample_dma

Parametrised successor to the custom master/slave sample mover in the FFT datapath. Exposes an Avalon-MM slave for CSR access and direct sample-buffer loading. It owns a single-port on-chip SRAM holding the sample buffer, and runs an Avalon-MM master that moves a programmable number of samples between that buffer and system memory, in either direction. It sits between the HPS/Avalon fabric and the FFT sample buffer.

## Interface
Parameters:
- MASTER_ADDRESSWIDTH, 32, master byte-address width
- DATAWIDTH, 32, Avalon data width (slave and master)
- SAMPLE_WIDTH, 16, SRAM word width; must be ≤ DATAWIDTH
- DEPTH_LOG2, 9, buffer depth = 2**DEPTH_LOG2 words
- SLAVE_ADDRESSWIDTH, DEPTH_LOG2+1, slave word-address width

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- slave_chipselect, slave_read, slave_write  in  1  Avalon slave strobes
- slave_address  in  SLAVE_ADDRESSWIDTH  bit MSB=0: buffer word; MSB=1: CSR index in bits [1:0]
- slave_writedata  in  DATAWIDTH
- slave_readdata  out  DATAWIDTH  registered
- slave_readdatavalid  out  1  one-cycle pulse
- master_address  out  MASTER_ADDRESSWIDTH
- master_write, master_read  out  1
- master_writedata  out  DATAWIDTH
- master_readdata  in  DATAWIDTH
- master_readdatavalid, master_waitrequest  in  1
- f_wren, f_rden  out  1  SRAM strobes
- f_address  out  DEPTH_LOG2
- f_data  out  SAMPLE_WIDTH
- f_q  in  SAMPLE_WIDTH  SRAM read data, valid 1 cycle after f_rden
- irq  out  1  only with FFT_DMA_IRQ_EN

## Operation
- CSR map:
  - 0 CTRL: write bit0=start (self-clearing), bit1=dir (0 buffer→memory, 1 memory→buffer).
  - 1 ADDR: master base byte address.
  - 2 LENGTH: word count.
  - 3 STATUS: bit0 busy, bit1 done (sticky), bit2 err (sticky); a write of 1 clears the corresponding sticky bit.
- Buffer slave access, not busy:
  - Write stores writedata[SAMPLE_WIDTH-1:0].
  - Read returns the sample zero-extended to DATAWIDTH.
- Buffer slave access while busy:
  - Writes are dropped and set err.
  - Reads return 0 with normal latency.
- Start while busy is ignored and sets err.
- Start with LENGTH=0 sets done immediately; busy never asserts.
- LENGTH > 2**DEPTH_LOG2 is clamped to 2**DEPTH_LOG2.
- FSM states: IDLE, FETCH, FWAIT, WR, RD, RWAIT, STORE, DONE.
- dir=0 (buffer→memory): IDLE → FETCH (f_rden) → FWAIT → WR. WR holds master_write until !master_waitrequest, then goes to FETCH, or to DONE on the last word.
- dir=1 (memory→buffer): IDLE → RD. RD holds master_read until !master_waitrequest → RWAIT, which waits for master_readdatavalid. RWAIT → STORE (f_wren, readdata truncated to SAMPLE_WIDTH). STORE → RD, or → DONE on the last word.
- DONE: set done, clear busy → IDLE.
- One outstanding master transaction at a time.
- Addressing:
  - master_address = ADDR + i*(DATAWIDTH/8), wrapping modulo 2**MASTER_ADDRESSWIDTH.
  - Buffer index i runs from 0 to LENGTH-1.
- master_writedata is the buffer word zero-extended to DATAWIDTH.
- f_* ownership: the FSM owns f_* while busy; the slave owns it otherwise.

## Timing
- Reset values: every output is 0; all CSRs are 0; FSM in IDLE. Reset mid-transfer drops master strobes immediately (asynchronously) and abandons the transfer; done is not set.
- All outputs are registered.
- Slave buffer write accepted in cycle n: f_wren is high in n+1.
- Slave buffer read in cycle n:
  - f_rden is high in n+1.
  - f_q is valid in n+2.
  - slave_readdata and slave_readdatavalid are high in n+3.
- CSR read in cycle n: slave_readdatavalid is high in n+1.
- Start written in cycle n: busy=1 and the FSM leaves IDLE in n+1.
- dir=0 with zero waitrequest: 3 cycles per word (FETCH, FWAIT, WR).
- dir=1 with zero waitrequest and readdatavalid one cycle after acceptance: 3 cycles per word.
- master_address and master_writedata are stable while master_waitrequest is high.

## Configuration
- FFT_DMA_IRQ_EN defined: adds the irq output.
  - irq is a level signal equal to STATUS.done | STATUS.err.
  - It clears when software clears both bits.
  - CSR 0 bit2 is an irq mask (1 = enabled, reset 0); irq = mask & (done|err).
- Macro undefined: no irq port; CTRL bit2 reads 0 and writes to it are ignored.

## Test plan
- Slave writes 0x0100+i to buffer words 0..255, then reads back words 0, 128, 255 → readdata 0x00000100, 0x00000180, 0x000001FF, each at n+3.
- ADDR=0x1000_0000, LENGTH=512, dir=0, start, with master_waitrequest high 3 of every 4 cycles → 512 writes to addresses 0x1000_0000..0x1000_07FC carrying the buffer contents; done=1, busy=0, err=0.
- dir=1, LENGTH=4, memory returns 0xABCD1234+k → buffer words 0..3 hold 0x1234..0x1237; no f_wren before the corresponding readdatavalid.
- During a busy transfer, a slave buffer write and a second start → buffer unchanged, transfer completes, err=1.
- Edge cases:
  - LENGTH=0 → done at n+1, no master strobes.
  - LENGTH=1000 → exactly 512 transfers.
- rst asserted mid-transfer with master_write high → master_write=0 immediately; STATUS=0 after release; a subsequent start runs normally. With FFT_DMA_IRQ_EN, irq rises only once mask is set and done=1.
